// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
//   UART transmitter fed directly from the read side of a byte FIFO. Whenever
//   the serializer is idle and the FIFO is not empty, it pops one byte and
//   sends it as: start bit, data bits LSB first, optional parity bit, and
//   1 or 2 stop bits. Bit timing comes from an internal divide-by-clks_per_bit
//   counter.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   fifo_empty  in   FIFO empty flag, looked at only while idle
//   fifo_data   in   FIFO read data, valid the cycle after fifo_read
//   fifo_read   out  one-cycle pop strobe (FIFO read enable)
//   tx          out  serial line, idle high, registered
//   busy        out  high from the pop strobe until the last stop bit ends
//   frame_done  out  one-cycle pulse in the final cycle of the last stop bit
//
// FIFO handshake: fifo_read is a single-cycle strobe issued only when
// fifo_empty was low in IDLE; the FIFO presents the popped byte on fifo_data
// one cycle later, which is when the LOAD state captures it. There is no
// back-pressure on the FIFO side.

module uart_tx_fifo_drain #(
  parameter int clks_per_bit = 868,
  parameter int data_bits    = 8,
  parameter bit parity_en    = 1'b0,
  parameter bit parity_odd   = 1'b0,
  parameter int stop_bits    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [data_bits-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW = $clog2(clks_per_bit);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t               state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [3:0]           idx, idx_next;
  logic [data_bits-1:0] shreg, shreg_next;
  logic                 par, par_next;
  logic                 tx_next;
  logic                 read_next;
  logic                 bit_end;

  assign bit_end = (cnt == CW'(clks_per_bit - 1));
  assign busy    = (state != IDLE);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shreg_next = shreg;
    par_next   = par;
    read_next  = 1'b0;
    frame_done = 1'b0;
    tx_next    = 1'b1;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          read_next  = 1'b1;
          state_next = POP;
        end
      end
      // fifo_read is high during this cycle; data arrives in the next one.
      POP: state_next = LOAD;
      LOAD: begin
        shreg_next = fifo_data;
        par_next   = (^fifo_data) ^ parity_odd;
        cnt_next   = '0;
        idx_next   = '0;
        state_next = START;
      end
      START: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = DATA;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shreg_next = shreg >> 1;
          if (idx == 4'(data_bits - 1)) begin
            idx_next   = '0;
            state_next = parity_en ? PARITY : STOP;
          end else begin
            idx_next = idx + 4'd1;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = STOP;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      STOP: begin
        // idx is reused to count stop bits.
        if (bit_end) begin
          cnt_next = '0;
          if (idx == 4'(stop_bits - 1)) begin
            idx_next   = '0;
            frame_done = 1'b1;
            state_next = IDLE;
          end else begin
            idx_next = idx + 4'd1;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // tx is registered from the level the line should hold in the next state,
    // so it changes exactly on the state boundary and never glitches.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      PARITY:  tx_next = par;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tx        <= 1'b1;
      fifo_read <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      shreg     <= shreg_next;
      par       <= par_next;
      tx        <= tx_next;
      fifo_read <= read_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Testbench for uart_tx_fifo_drain. Four instances share clock and reset:
//   0: no parity, 1 stop bit     1: even parity     2: odd parity
//   3: no parity, 2 stop bits (random stream)
// All use clks_per_bit=4, data_bits=8. Each instance has a behavioural FIFO
// with one-cycle read latency. Expected line waveforms are built from the
// frame format (start, LSB-first data, parity, stops) and compared per cycle.

module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fempty = 4'hF;
  logic [7:0] fdata [4] = '{default: 8'h00};
  logic [3:0] rd_w, tx_w, busy_w, done_w;
  logic [3:0] push_v = 4'h0;
  logic [7:0] push_b [4] = '{default: 8'h00};
  logic [7:0] fq [4][$];
  int         underflows [4] = '{default: 0};

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  bit cap_tx[$], cap_rd[$], cap_busy[$], cap_done[$], cap_empty[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  uart_tx_fifo_drain #(.clks_per_bit(CPB), .data_bits(8), .parity_en(1'b0),
                       .parity_odd(1'b0), .stop_bits(1)) u_base (
    .clock(clk), .reset(rst), .fifo_empty(fempty[0]), .fifo_data(fdata[0]),
    .fifo_read(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));

  uart_tx_fifo_drain #(.clks_per_bit(CPB), .data_bits(8), .parity_en(1'b1),
                       .parity_odd(1'b0), .stop_bits(1)) u_par_even (
    .clock(clk), .reset(rst), .fifo_empty(fempty[1]), .fifo_data(fdata[1]),
    .fifo_read(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));

  uart_tx_fifo_drain #(.clks_per_bit(CPB), .data_bits(8), .parity_en(1'b1),
                       .parity_odd(1'b1), .stop_bits(1)) u_par_odd (
    .clock(clk), .reset(rst), .fifo_empty(fempty[2]), .fifo_data(fdata[2]),
    .fifo_read(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));

  uart_tx_fifo_drain #(.clks_per_bit(CPB), .data_bits(8), .parity_en(1'b0),
                       .parity_odd(1'b0), .stop_bits(2)) u_stop2 (
    .clock(clk), .reset(rst), .fifo_empty(fempty[3]), .fifo_data(fdata[3]),
    .fifo_read(rd_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]));

  // ---------------- FIFO models ----------------
  // Pop on a read strobe (data visible the next cycle), then accept a push.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rd_w[i]) begin
        if (fq[i].size() == 0) underflows[i] <= underflows[i] + 1;
        else fdata[i] <= fq[i].pop_front();
      end
      if (push_v[i]) fq[i].push_back(push_b[i]);
      fempty[i] <= (fq[i].size() == 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic push(input int i, input logic [7:0] b);
    push_b[i] = b;
    push_v[i] = 1'b1;
    @(negedge clk);
    push_v[i] = 1'b0;
  endtask

  task automatic capture(input int i, input int n);
    cap_tx.delete(); cap_rd.delete(); cap_busy.delete();
    cap_done.delete(); cap_empty.delete();
    for (int k = 0; k < n; k++) begin
      cap_tx.push_back(tx_w[i]);
      cap_rd.push_back(rd_w[i]);
      cap_busy.push_back(busy_w[i]);
      cap_done.push_back(done_w[i]);
      cap_empty.push_back(fempty[i]);
      @(negedge clk);
    end
  endtask

  // ---------------- reference model ----------------
  // sel: 0 tx, 1 frame_done, 2 fifo_read, 3 fifo_empty
  function automatic bit cap_at(input int sel, input int k);
    case (sel)
      0:       return cap_tx[k];
      1:       return cap_done[k];
      2:       return cap_rd[k];
      default: return cap_empty[k];
    endcase
  endfunction

  function automatic int find_first(input int sel, input int from, input bit val);
    for (int k = from; k < cap_tx.size(); k++)
      if (cap_at(sel, k) == val) return k;
    return -1;
  endfunction

  function automatic int count_ones(input int sel);
    int n = 0;
    for (int k = 0; k < cap_tx.size(); k++) if (cap_at(sel, k)) n++;
    return n;
  endfunction

  // Number of cycles where the captured line differs from the ideal frame
  // starting at s; -1 if the frame does not fit in the capture.
  function automatic int frame_mismatch(input int s, input logic [7:0] b,
                                        input bit pe, input bit po, input int sb);
    bit bits[$];
    int mm = 0;
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(b[k]);
    if (pe) bits.push_back((^b) ^ po);
    for (int k = 0; k < sb; k++) bits.push_back(1'b1);
    if (s < 0 || s + bits.size() * CPB > cap_tx.size()) return -1;
    for (int k = 0; k < bits.size() * CPB; k++)
      if (cap_tx[s + k] != bits[k / CPB]) mm++;
    return mm;
  endfunction

  function automatic logic [7:0] decode_at(input int s);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = cap_tx[s + CPB * (k + 1) + CPB / 2];
    return b;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_w !== 4'hF)   begin errors++; $display("FAIL reset_tx: got %b expected 1111", tx_w); end
    checks++; if (rd_w !== 4'h0)   begin errors++; $display("FAIL reset_fifo_read: got %b expected 0000", rd_w); end
    checks++; if (busy_w !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b expected 0000", busy_w); end
    checks++; if (done_w !== 4'h0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0000", done_w); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    int s, c0, d, n;
    push(0, 8'hA5);
    capture(0, 80);
    s  = find_first(0, 0, 1'b0);
    c0 = find_first(3, 0, 1'b0);
    d  = find_first(1, 0, 1'b1);
    n = count_ones(2);
    checks++; if (n != 1) begin errors++; $display("FAIL single_pop_count: got %0d expected 1", n); end
    checks++; if (s != c0 + 3 || c0 < 0) begin errors++; $display("FAIL single_latency: start at %0d expected %0d", s, c0 + 3); end
    n = frame_mismatch(s, 8'hA5, 1'b0, 1'b0, 1);
    checks++; if (n != 0) begin errors++; $display("FAIL single_waveform: %0d bad cycles expected 0", n); end
    n = count_ones(1);
    checks++; if (n != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", n); end
    // Frame of 10 bits x 4 cycles: the pulse is in the 40th cycle of the frame.
    checks++; if (d != s + 39) begin errors++; $display("FAIL single_done_pos: got %0d expected %0d", d, s + 39); end
    if (d < 0 || d + 1 >= cap_busy.size()) begin
      errors++; checks++; $display("FAIL single_busy_fall: frame_done at %0d, no busy window", d);
    end else begin
      checks++;
      if (cap_busy[d] !== 1'b1 || cap_busy[d + 1] !== 1'b0) begin
        errors++; $display("FAIL single_busy_fall: got %b%b expected 10", cap_busy[d], cap_busy[d + 1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2, d1, n;
    logic [7:0] b;
    push(0, 8'h00);
    push(0, 8'hFF);
    capture(0, 120);
    s1 = find_first(0, 0, 1'b0);
    d1 = find_first(1, 0, 1'b1);
    s2 = (d1 < 0) ? -1 : find_first(0, d1 + 1, 1'b0);
    n = count_ones(2);
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_pop_count: got %0d expected 2", n); end
    if (s1 < 0 || s2 < 0 || s2 + 40 > cap_tx.size()) begin
      errors++; checks++;
      $display("FAIL b2b_frames: starts %0d %0d, done %0d, two frames expected", s1, s2, d1);
    end else begin
      checks++; if (s2 - d1 - 1 != 3) begin errors++; $display("FAIL b2b_gap: got %0d expected 3", s2 - d1 - 1); end
      b = decode_at(s1);
      checks++; if (b !== 8'h00) begin errors++; $display("FAIL b2b_byte0: got %h expected 00", b); end
      b = decode_at(s2);
      checks++; if (b !== 8'hFF) begin errors++; $display("FAIL b2b_byte1: got %h expected ff", b); end
      n = frame_mismatch(s1, 8'h00, 1'b0, 1'b0, 1) + frame_mismatch(s2, 8'hFF, 1'b0, 1'b0, 1);
      checks++; if (n != 0) begin errors++; $display("FAIL b2b_waveform: %0d bad cycles expected 0", n); end
    end
    n = count_ones(1);
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", n); end
  endtask

  task automatic test_empty();
    int n_rd = 0, n_low = 0, n_busy = 0;
    for (int k = 0; k < 100; k++) begin
      if (rd_w[0] !== 1'b0)   n_rd++;
      if (tx_w[0] !== 1'b1)   n_low++;
      if (busy_w[0] !== 1'b0) n_busy++;
      @(negedge clk);
    end
    checks++; if (n_rd != 0)   begin errors++; $display("FAIL empty_fifo_read: %0d cycles high expected 0", n_rd); end
    checks++; if (n_low != 0)  begin errors++; $display("FAIL empty_tx: %0d cycles low expected 0", n_low); end
    checks++; if (n_busy != 0) begin errors++; $display("FAIL empty_busy: %0d cycles high expected 0", n_busy); end
  endtask

  task automatic test_parity();
    int s, d, n;
    for (int i = 1; i <= 2; i++) begin
      bit po;
      po = (i == 2);
      push(i, 8'h07);
      capture(i, 70);
      s = find_first(0, 0, 1'b0);
      d = find_first(1, 0, 1'b1);
      n = frame_mismatch(s, 8'h07, 1'b1, po, 1);
      checks++; if (n != 0) begin errors++; $display("FAIL parity_waveform_odd%0d: %0d bad cycles expected 0", po, n); end
      // Three ones: even parity bit 1, odd parity bit 0.
      if (s < 0 || s + 9 * CPB + 2 >= cap_tx.size()) begin
        errors++; checks++; $display("FAIL parity_bit_odd%0d: no frame seen", po);
      end else begin
        checks++;
        if (cap_tx[s + 9 * CPB + 2] !== !po) begin
          errors++; $display("FAIL parity_bit_odd%0d: got %b expected %b", po, cap_tx[s + 9 * CPB + 2], !po);
        end
      end
      checks++; if (d != s + 11 * CPB - 1) begin errors++; $display("FAIL parity_frame_len_odd%0d: done at %0d expected %0d", po, d, s + 11 * CPB - 1); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int w = 0, n, rd_hits = 0, s;
    push(0, 8'h5A);
    while (tx_w[0] !== 1'b0 && w < 50) begin @(negedge clk); w++; end
    checks++;
    if (w >= 50) begin
      errors++; $display("FAIL rstmid_start: no start bit within %0d cycles", w);
    end else begin
      // Start bit is 4 cycles; data bit 3 spans offsets 16..19 of the frame.
      repeat (4 + 3 * CPB + 1) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (tx_w[0] !== 1'b1)   begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx_w[0]); end
      checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy_w[0]); end
      @(negedge clk);
      push(0, 8'h3C);
      for (int k = 0; k < 4; k++) begin
        if (rd_w[0] !== 1'b0) rd_hits++;
        @(negedge clk);
      end
      checks++; if (rd_hits != 0) begin errors++; $display("FAIL rstmid_no_pop: %0d pops during reset expected 0", rd_hits); end
      rst = 1'b0;
      capture(0, 70);
      s = find_first(0, 0, 1'b0);
      n = frame_mismatch(s, 8'h3C, 1'b0, 1'b0, 1);
      checks++; if (n != 0) begin errors++; $display("FAIL rstmid_next_frame: %0d bad cycles expected 0", n); end
      n = count_ones(2);
      checks++; if (n != 1) begin errors++; $display("FAIL rstmid_pop_count: got %0d expected 1", n); end
    end
  endtask

  task automatic test_random();
    int got = 0, frame_err = 0, uf = 0;
    bit timeout = 1'b0;
    exp_q.delete();
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          logic [7:0] b;
          b = 8'($urandom);
          exp_q.push_back(b);
          push(3, b);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(10, 80)) @(negedge clk);
        end
      end
      begin
        for (int n = 0; n < 1000 && !timeout; n++) begin
          int w;
          logic [7:0] b, e;
          w = 0;
          while (tx_w[3] !== 1'b0 && w < 2000) begin @(negedge clk); w++; end
          if (w >= 2000) begin
            timeout = 1'b1;
          end else begin
            repeat (CPB / 2) @(negedge clk);
            if (tx_w[3] !== 1'b0) frame_err++;
            for (int k = 0; k < 8; k++) begin repeat (CPB) @(negedge clk); b[k] = tx_w[3]; end
            for (int k = 0; k < 2; k++) begin repeat (CPB) @(negedge clk); if (tx_w[3] !== 1'b1) frame_err++; end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (b !== e) begin errors++; $display("FAIL random_byte%0d: got %h expected %h", n, b, e); end
            got++;
          end
        end
      end
    join
    checks++; if (got != 1000) begin errors++; $display("FAIL random_count: got %0d frames expected 1000", got); end
    checks++; if (frame_err != 0) begin errors++; $display("FAIL random_framing: %0d bad start/stop samples expected 0", frame_err); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL random_leftover: %0d bytes not seen expected 0", exp_q.size()); end
    for (int i = 0; i < 4; i++) uf += underflows[i];
    checks++; if (uf != 0) begin errors++; $display("FAIL underflow: %0d pops from empty FIFO expected 0", uf); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty();
    test_parity();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
